// File: rtl/bf_out_uart.sv
// rtl/bf_out_uart.sv - BF core output capture FIFO feeding an 8N1 UART transmitter
module bf_out_uart #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               out,
    input  logic                     out_enable,
    output logic                     tx,
    output logic                     tx_busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]              BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic [7:0]               mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
    state_t                   state, state_n;
    logic [7:0]               shift, shift_n;
    logic [BW-1:0]            baud, baud_n;
    logic [2:0]               bit_idx, bit_idx_n;
    logic                     tx_n;
    logic                     full, push, pop;

    // Pointers carry one extra wrap bit so the plain difference is the occupancy.
    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == FULL_COUNT);
    assign pop        = (state == ST_IDLE) && (fifo_count != '0);
    assign push       = out_enable && (!full || pop);
    assign tx_busy    = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
            shift    <= '0;
            baud     <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (out_enable && full && !pop) begin
                overflow <= 1'b1;
            end
            state   <= state_n;
            shift   <= shift_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    shift_n = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
                    baud_n  = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (baud == BAUD_LAST) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level is decided from next-state values so tx itself is a flop.
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bf_out_uart.sv
// tb/tb_bf_out_uart.sv - self-checking bench for bf_out_uart
module tb_bf_out_uart;

    localparam int C = 4;
    localparam int L = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   out;
    logic         out_enable;
    logic         tx;
    logic         tx_busy;
    logic [L:0]   fifo_count;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    bf_out_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(L)) dut (
        .clock      (clock),
        .reset      (reset),
        .out        (out),
        .out_enable (out_enable),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    // Line receiver: one frame per falling start edge, bits sampled mid-bit.
    logic [7:0] rx_q [$];
    int         rx_t [$];
    bit         rx_ok [$];
    int         cyc = 0;
    bit         in_frame = 0;
    int         idx = 0;
    int         start_cyc = 0;
    logic [9:0] sh;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (!reset) begin
            in_frame = 0;
        end else if (!in_frame && tx == 1'b0) begin
            in_frame  = 1;
            idx       = 0;
            start_cyc = cyc;
            sh        = '0;
        end
        if (in_frame) begin
            if (idx % C == C / 2) sh[idx / C] = tx;
            idx = idx + 1;
            if (idx == 10 * C) begin
                in_frame = 0;
                rx_q.push_back(sh[8:1]);
                rx_t.push_back(start_cyc);
                rx_ok.push_back(sh[0] == 1'b0 && sh[9] == 1'b1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        out        = d;
        out_enable = 1'b1;
        tick();
        out_enable = 1'b0;
        out        = 8'($urandom);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_ok.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clear_rx();
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        #1;
        check({name, "_frames"}, rx_q.size(), n);
    endtask

    task automatic check_rx(input int i, input logic [7:0] exp, input string name);
        if (i < rx_q.size()) begin
            check($sformatf("%s_byte%0d", name, i), rx_q[i], exp);
            check($sformatf("%s_framing%0d", name, i), rx_ok[i], 1);
        end else begin
            check($sformatf("%s_missing%0d", name, i), rx_q.size(), i + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        vecs[0] = '{8'h41, 10'b1010000010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h3C, 10'b1001111000};

        reset      = 1'b0;
        out        = 8'h00;
        out_enable = 1'b0;
        tick();
        tick();
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;

        // Single-byte frames, checked cycle by cycle against the table.
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
            push_byte(vecs[i].data);
            @(negedge clock);
            check($sformatf("v%0d_count_push", i), fifo_count, 1);
            check($sformatf("v%0d_tx_pre", i), tx, 1);
            check($sformatf("v%0d_busy_pre", i), tx_busy, 1);
            tick();
            check($sformatf("v%0d_count_pop", i), fifo_count, 0);
            for (int k = 0; k < 10 * C; k++) begin
                @(negedge clock);
                check($sformatf("v%0d_tx_k%0d", i, k), tx, vecs[i].frame[k / C]);
                check($sformatf("v%0d_busy_k%0d", i, k), tx_busy, 1);
                tick();
            end
            @(negedge clock);
            check($sformatf("v%0d_tx_end", i), tx, 1);
            check($sformatf("v%0d_busy_end", i), tx_busy, 0);
            check($sformatf("v%0d_count_end", i), fifo_count, 0);
        end

        // Burst of three bytes.
        repeat (3) tick();
        clear_rx();
        peak = 0;
        push_byte(8'h48);
        if (fifo_count > peak) peak = fifo_count;
        push_byte(8'h69);
        if (fifo_count > peak) peak = fifo_count;
        push_byte(8'h21);
        for (int k = 0; k < 6; k++) begin
            if (fifo_count > peak) peak = fifo_count;
            tick();
        end
        check("burst_peak", peak, 2);
        wait_frames(3, 300, "burst");
        check_rx(0, 8'h48, "burst");
        check_rx(1, 8'h69, "burst");
        check_rx(2, 8'h21, "burst");
        if (rx_t.size() == 3) begin
            check("burst_gap01", rx_t[1] - rx_t[0], 41);
            check("burst_gap12", rx_t[2] - rx_t[1], 41);
            check("burst_total", rx_t[2] + 40 - rx_t[0], 122);
        end
        repeat (3) tick();
        check("burst_busy_end", tx_busy, 0);

        // Overflow: ten bytes into an eight-deep FIFO.
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        check("ovf_flag", overflow, 1);
        check("ovf_count", fifo_count, 8);
        wait_frames(9, 9 * 41 + 50, "ovf");
        for (int i = 0; i < 9; i++) check_rx(i, 8'(i), "ovf");
        repeat (100) tick();
        check("ovf_no_extra", rx_q.size(), 9);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with a push on the exact edge Idle pops.
        do_reset();
        check("fullpop_ovf_rst", overflow, 0);
        push_byte(8'h50);
        for (int i = 1; i <= 8; i++) push_byte(8'(8'h60 + i));
        check("fullpop_full", fifo_count, 8);
        repeat (33) tick();
        check("fullpop_pre_count", fifo_count, 8);
        check("fullpop_pre_tx", tx, 1);
        push_byte(8'h69);
        check("fullpop_count", fifo_count, 8);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_tx_start", tx, 0);
        wait_frames(10, 10 * 41 + 50, "fullpop");
        check_rx(0, 8'h50, "fullpop");
        for (int i = 1; i <= 9; i++) check_rx(i, 8'(8'h60 + i), "fullpop");
        check("fullpop_ovf_end", overflow, 0);

        // Asynchronous reset during data bit 3 of 0xA5.
        do_reset();
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (15) tick();
        check("rstmid_bit3", tx, 0);
        check("rstmid_count_pre", fifo_count, 2);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_busy", tx_busy, 0);
        check("rstmid_ovf", overflow, 0);
        tick();
        tick();
        reset = 1'b1;
        clear_rx();
        peak = 1;
        for (int k = 0; k < 200; k++) begin
            if (tx == 1'b0) peak = 0;
            tick();
        end
        check("rstmid_tx_quiet", peak, 1);
        check("rstmid_no_frames", rx_q.size(), 0);
        check("rstmid_busy_after", tx_busy, 0);

        // Pointer wrap: 20 bytes spaced so the FIFO never fills.
        clear_rx();
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(8'h80 + 3 * i));
            repeat (29) tick();
        end
        wait_frames(20, 1000, "wrap");
        for (int i = 0; i < 20; i++) check_rx(i, 8'(8'h80 + 3 * i), "wrap");
        repeat (3) tick();
        check("wrap_ovf", overflow, 0);
        check("wrap_count", fifo_count, 0);
        check("wrap_busy", tx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_out_uart.md
Name: bf_out_uart

Overview:
- Downstream consumer of the BF core's output port.
- Captures every byte the core emits via out/out_enable into a small FIFO.
- Serializes the bytes onto a single UART TX line: 8N1, LSB first, idle high.
- Decouples the core, which can emit one byte per clock, from the slow serial line. Exposes occupancy, busy and overflow status.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
FIFO_DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8 entries).

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
out  input  8  byte from BF core (sampled only when out_enable=1).
out_enable  input  1  write strobe from BF core; one byte captured per clock edge while high.
tx  output  1  UART serial output; idle high.
tx_busy  output  1  1 while FIFO non-empty or a frame is in progress.
fifo_count  output  FIFO_DEPTH_LOG2+1  number of bytes buffered (excludes byte in shifter).
overflow  output  1  sticky: a byte was dropped because FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to their reset values immediately, regardless of clock.
  - tx=1, tx_busy=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared; state=Idle; bit and baud counters=0.
  - Reset mid-frame aborts the frame: tx returns high at once, and buffered bytes are discarded.
- FIFO write:
  - On posedge with out_enable=1 and FIFO not full, push `out`; fifo_count increments after that edge.
  - Full (fifo_count == 2**FIFO_DEPTH_LOG2) with no pop that edge: byte dropped, overflow<=1.
  - Once set, overflow stays set until reset.
  - Push and pop on the same edge: both take effect, count unchanged, no overflow even if full.
- FIFO ordering: strict FIFO order; pointers wrap modulo depth; count is the full-width difference.
- TX state machine (Idle, Start, Data, Stop):
  - Idle:
    - tx=1.
    - If fifo_count != 0 at posedge: pop head into 8-bit shift register, baud counter<=0, go to Start.
    - A byte pushed at edge E0 into an empty FIFO while Idle is popped at E0+1, and tx falls after E0+1.
  - Start: tx=0 for CLKS_PER_BIT cycles, then go to Data with bit index 0.
  - Data:
    - tx=shift[0] for CLKS_PER_BIT cycles per bit.
    - Shift right after each bit.
    - After bit index 7 completes, go to Stop.
  - Stop: tx=1 for CLKS_PER_BIT cycles, then go to Idle.
  - Frame timing:
    - One frame = 10*CLKS_PER_BIT cycles from tx falling edge to end of Stop.
    - Back-to-back frames have exactly one extra Idle cycle (tx high) between Stop end and the next start bit.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - On terminal count it resets to 0 and advances bit/state.
  - Width is clog2(CLKS_PER_BIT).
- tx is registered (glitch-free): driven from state/shift register flops, never from FIFO read data combinationally.
- tx_busy = (state != Idle) || (fifo_count != 0); it is combinational from registered state.
- out_enable while in any TX state is accepted normally; the TX engine never stalls the writer.
- A value of out while out_enable=0 is ignored; no X-propagation into FIFO.

Test Plan:
1. Reset, then single byte:
   - Stimulus: CLKS_PER_BIT=4; push out=8'h41 ('A') for one cycle.
   - Required: tx low 1 cycle after capture for 4 cycles, then data 1,0,0,0,0,0,1,0 (4 cycles each), then high 4 cycles.
   - Required: tx_busy drops in the cycle after Stop ends; fifo_count 1 -> 0 on the pop edge.
2. Burst: push 'H','i','!' on 3 consecutive cycles.
   - Required: fifo_count peaks at 2 (first byte popped at edge after its push).
   - Required: three frames in order with one idle cycle between each; total 3*40+2 cycles of tx activity.
3. Overflow (FIFO_DEPTH_LOG2=3):
   - Stimulus: push 10 bytes 0x00..0x09 on consecutive cycles.
   - Required: 0x00 is shifted out, 0x01-0x08 are buffered, and 0x09 is dropped; overflow=1 and stays 1.
   - Required: exactly 9 frames emitted, values 0x00..0x08.
4. Full with simultaneous pop:
   - Stimulus: fill FIFO to 8 while a frame is in progress; push one more on the exact edge Idle pops.
   - Required: byte accepted, count stays 8, overflow=0.
5. Reset mid-frame:
   - Stimulus: assert reset=0 asynchronously during Data bit 3 of 0xA5, with 2 bytes buffered.
   - Required: tx=1, fifo_count=0, tx_busy=0, overflow=0 immediately.
   - Required: after release, no further frames without new pushes.
6. Pointer wrap:
   - Stimulus: stream 20 bytes at a rate that never fills the FIFO.
   - Required: all 20 appear on tx in order; overflow=0; fifo_count returns to 0.
